// File: rtl/fp_sign_pkg.sv
// fp_sign_pkg: shared op encoding, format widths and sign-index helper for the sign-application stage
package fp_sign_pkg;
    typedef enum logic [1:0] {
        SIGN_COPY   = 2'd0,
        SIGN_NEG    = 2'd1,
        SIGN_XOR    = 2'd2,
        SIGN_SETNEG = 2'd3
    } sign_op_e;

    localparam int HALF_BITS   = 16;
    localparam int SINGLE_BITS = 32;

    function automatic int sign_idx(input string prec);
        return (prec == "SINGLE") ? SINGLE_BITS - 1 : HALF_BITS - 1;
    endfunction
endpackage

// File: rtl/fp_skid_buf.sv
// fp_skid_buf: 2-entry valid/ready register slice (output register plus one skid entry)
//   clk, rst_n         : clock, synchronous active-low reset
//   in_valid/in_ready  : upstream handshake, in_data payload
//   out_valid/out_ready: downstream handshake, out_data payload (registered)
module fp_skid_buf #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         r_or_valid;
    logic [W-1:0] r_or_data;
    logic         r_sk_full;
    logic [W-1:0] r_sk_data;
    logic         r_in_ready;
    logic         w_acc;
    logic         w_con;
    logic         w_sk_nxt;

    assign in_ready  = r_in_ready;
    assign out_valid = r_or_valid;
    assign out_data  = r_or_data;

    // A beat spills into the skid entry only when the output register is held this cycle;
    // a consume with the skid full drains it (no accept can coincide since in_ready is low).
    always_comb begin
        w_acc    = in_valid & r_in_ready;
        w_con    = r_or_valid & out_ready;
        w_sk_nxt = (w_con & r_sk_full) ? 1'b0 : (w_acc & r_or_valid & ~w_con) ? 1'b1 : r_sk_full;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_or_valid <= 1'b0;
            r_or_data  <= '0;
            r_sk_full  <= 1'b0;
            r_sk_data  <= '0;
            r_in_ready <= 1'b0;
        end else begin
            r_in_ready <= ~w_sk_nxt;
            r_sk_full  <= w_sk_nxt;
            if (w_con && r_sk_full) begin
                r_or_data <= r_sk_data;
            end else if (w_acc && (!r_or_valid || w_con)) begin
                r_or_data  <= in_data;
                r_or_valid <= 1'b1;
            end else if (w_con) begin
                r_or_valid <= 1'b0;
            end
            if (w_acc && r_or_valid && !w_con) r_sk_data <= in_data;
        end
    end
endmodule

// File: rtl/fp_sign_apply.sv
// fp_sign_apply: applies a sign (copy/negate/xor/force-negative) to a HALF or SINGLE float on a valid/ready stream
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : input handshake; in_a value, in_b sign source (MSB only), in_op operation
//   out_valid/out_ready : output handshake; out_data signed result, one cycle after accept
module fp_sign_apply
    import fp_sign_pkg::*;
#(
    parameter int    BITS      = 16,
    parameter string PRECISION = "HALF"
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] in_a,
    input  logic [BITS-1:0] in_b,
    input  logic [1:0]      in_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] out_data
);
    generate
        if (!((PRECISION == "HALF" || PRECISION == "SINGLE") && BITS == sign_idx(PRECISION) + 1)) begin : g_bad_params
            $error("fp_sign_apply: BITS must be 16 for HALF or 32 for SINGLE");
        end
    endgenerate

    sign_op_e        w_op;
    logic            w_sign;
    logic [BITS-1:0] w_res;
    logic            w_unused;

    // Only the sign bit of in_b carries information.
    assign w_unused = ^in_b[BITS-2:0];

    // NaN/Inf/zero/subnormal are not special: the sign is applied unconditionally.
    always_comb begin
        w_op   = sign_op_e'(in_op);
        w_sign = (w_op == SIGN_COPY) ? in_b[BITS-1] :
                 (w_op == SIGN_NEG)  ? ~in_a[BITS-1] :
                 (w_op == SIGN_XOR)  ? (in_a[BITS-1] ^ in_b[BITS-1]) : 1'b1;
        w_res  = {w_sign, in_a[BITS-2:0]};
    end

    fp_skid_buf #(.W(BITS)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );
endmodule

// File: tb/tb_fp_sign_apply.sv
// tb_fp_sign_apply: directed vectors, back-pressure, stall, reset and random scoreboard checks for fp_sign_apply
module tb_fp_sign_apply;
    logic        clk;
    logic        rst_n;
    logic        h_valid, h_ready, h_ovalid, h_ordy;
    logic [15:0] h_a, h_b, h_odata;
    logic [1:0]  h_op;
    logic        s_valid, s_ready, s_ovalid, s_ordy;
    logic [31:0] s_a, s_b, s_odata;
    logic [1:0]  s_op;

    int checks = 0;
    int errors = 0;
    int n_acc;
    int cyc;
    logic [15:0] q[$];
    logic [15:0] hold;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[8];

    fp_sign_apply #(.BITS(16), .PRECISION("HALF")) u_h (
        .clk(clk), .rst_n(rst_n), .in_valid(h_valid), .in_ready(h_ready),
        .in_a(h_a), .in_b(h_b), .in_op(h_op),
        .out_valid(h_ovalid), .out_ready(h_ordy), .out_data(h_odata)
    );

    fp_sign_apply #(.BITS(32), .PRECISION("SINGLE")) u_s (
        .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(s_ready),
        .in_a(s_a), .in_b(s_b), .in_op(s_op),
        .out_valid(s_ovalid), .out_ready(s_ordy), .out_data(s_odata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        logic s;
        s = (op == 2'd0) ? b[15] : (op == 2'd1) ? ~a[15] : (op == 2'd2) ? (a[15] ^ b[15]) : 1'b1;
        return {s, a[14:0]};
    endfunction

    initial begin
        vecs[0] = '{2'd0, 16'h3C00, 16'h8000, 16'hBC00};
        vecs[1] = '{2'd1, 16'hBC00, 16'h0000, 16'h3C00};
        vecs[2] = '{2'd2, 16'hC000, 16'h8000, 16'h4000};
        vecs[3] = '{2'd3, 16'h0000, 16'h0000, 16'h8000};
        vecs[4] = '{2'd0, 16'hBC00, 16'h7FFF, 16'h3C00};
        vecs[5] = '{2'd1, 16'h0000, 16'hFFFF, 16'h8000};
        vecs[6] = '{2'd2, 16'h7E00, 16'h8000, 16'hFE00};
        vecs[7] = '{2'd3, 16'hFC00, 16'h0000, 16'hFC00};

        rst_n = 1'b0;
        h_valid = 1'b0; h_a = '0; h_b = '0; h_op = '0; h_ordy = 1'b1;
        s_valid = 1'b0; s_a = '0; s_b = '0; s_op = '0; s_ordy = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", 32'(h_ovalid), 0);
        chk("rst_out_data", 32'(h_odata), 0);
        chk("rst_in_ready", 32'(h_ready), 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", 32'(h_ready), 1);
        chk("post_rst_out_valid", 32'(h_ovalid), 0);

        for (int i = 0; i < 8; i++) begin
            h_valid = 1'b1; h_op = vecs[i].op; h_a = vecs[i].a; h_b = vecs[i].b;
            tick();
            chk($sformatf("vec%0d_data", i), 32'(h_odata), 32'(vecs[i].exp));
            chk($sformatf("vec%0d_valid", i), 32'(h_ovalid), 1);
            chk($sformatf("vec%0d_in_ready", i), 32'(h_ready), 1);
        end
        h_valid = 1'b0;
        tick();
        chk("b2b_drained", 32'(h_ovalid), 0);

        s_valid = 1'b1; s_op = 2'd0; s_a = 32'h7FC00000; s_b = 32'h80000000;
        tick();
        chk("single_copy_nan", s_odata, 32'hFFC00000);
        chk("single_copy_valid", 32'(s_ovalid), 1);
        s_op = 2'd1; s_a = 32'h7F800000; s_b = 32'h0;
        tick();
        chk("single_neg_inf", s_odata, 32'hFF800000);
        s_valid = 1'b0;
        tick();
        chk("single_drained", 32'(s_ovalid), 0);

        h_ordy = 1'b0; h_valid = 1'b1; h_op = 2'd3; h_b = 16'h0; h_a = 16'h0001;
        tick();
        chk("bp_beat1_out", 32'(h_odata), 32'h8001);
        chk("bp_in_ready_after1", 32'(h_ready), 1);
        h_a = 16'h0002;
        tick();
        chk("bp_in_ready_after2", 32'(h_ready), 0);
        h_a = 16'h0003;
        hold = h_odata;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("stall%0d_data", i), 32'(h_odata), 32'(hold));
            chk($sformatf("stall%0d_valid", i), 32'(h_ovalid), 1);
            chk($sformatf("stall%0d_in_ready", i), 32'(h_ready), 0);
        end
        chk("stall_held_value", 32'(hold), 32'h8001);
        h_ordy = 1'b1;
        tick();
        chk("bp_out2", 32'(h_odata), 32'h8002);
        chk("bp_in_ready_reopen", 32'(h_ready), 1);
        tick();
        chk("bp_out3", 32'(h_odata), 32'h8003);
        h_a = 16'h0004;
        tick();
        chk("bp_out4", 32'(h_odata), 32'h8004);
        h_valid = 1'b0;
        tick();
        chk("bp_done", 32'(h_ovalid), 0);

        h_ordy = 1'b0; h_valid = 1'b1; h_op = 2'd1; h_a = 16'h1234;
        tick();
        h_a = 16'h5678;
        tick();
        chk("mid_fill_sk", 32'(h_ready), 0);
        h_valid = 1'b0; rst_n = 1'b0;
        tick();
        chk("mid_rst_out_valid", 32'(h_ovalid), 0);
        chk("mid_rst_out_data", 32'(h_odata), 0);
        chk("mid_rst_in_ready", 32'(h_ready), 0);
        rst_n = 1'b1; h_ordy = 1'b1;
        tick();
        chk("mid_rst_in_ready_up", 32'(h_ready), 1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("mid_rst_no_stale%0d", i), 32'(h_ovalid), 0);
            tick();
        end

        n_acc = 0;
        cyc = 0;
        while ((n_acc < 10000 || q.size() != 0) && cyc < 60000) begin
            h_valid = (n_acc < 10000) ? ($urandom_range(0, 9) < 7) : 1'b0;
            h_op = 2'($urandom_range(0, 3));
            h_a = 16'($urandom);
            h_b = 16'($urandom);
            h_ordy = ($urandom_range(0, 9) < 7);
            if (h_ovalid && h_ordy) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_spurious: got %h expected no beat", h_odata);
                end else begin
                    chk("rand_data", 32'(h_odata), 32'(q.pop_front()));
                end
            end
            if (h_valid && h_ready) begin
                q.push_back(model(h_op, h_a, h_b));
                n_acc++;
            end
            tick();
            cyc++;
        end
        h_valid = 1'b0;
        chk("rand_queue_empty", 32'(q.size()), 0);
        chk("rand_accepted", 32'(n_acc), 10000);
        tick();
        chk("rand_final_idle", 32'(h_ovalid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_sign_apply.md
Name: fp_sign_apply

Overview:
- Streaming sign-application stage for HALF/SINGLE floats: the inverse of sign stripping.
- Takes a magnitude operand plus a sign-source operand and produces the signed result.
- Supports copysign, negate, sign-multiply (XOR) and force-negative.
- Sits between precision datapath stages on a valid/ready stream.
- Registered output, one-cycle latency, full throughput, 2-entry skid buffering so back-pressure never drops data.

Parameters:
- BITS, 16, operand width; must be 16 for HALF, 32 for SINGLE; any other pairing is an elaboration error.
- PRECISION, "HALF", "HALF" or "SINGLE"; sign bit is BITS-1.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  input beat accepted when in_valid & in_ready
- in_a  input  BITS  magnitude/value operand
- in_b  input  BITS  sign-source operand; only bit BITS-1 is used
- in_op  input  2  0=COPY, 1=NEG, 2=XOR, 3=SETNEG
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts
- out_data  output  BITS  signed result

Behaviour:
- Result formation:
  - Bits BITS-2:0 = in_a[BITS-2:0], passed unmodified.
  - Sign bit by op: COPY = in_b[BITS-1]; NEG = ~in_a[BITS-1]; XOR = in_a[BITS-1]^in_b[BITS-1]; SETNEG = 1.
  - No special-casing of NaN, Inf, zero or subnormals: the sign is applied to all (-0 is legal output).
  - Result is computed combinationally from the accepted beat and registered.
- Reset (rst_n low at a clk edge):
  - out_valid=0, out_data=0, in_ready=0, skid buffer empty.
  - in_ready rises to 1 on the first edge with rst_n high.
  - Reset mid-stream discards the output register and skid contents; no beat is emitted after reset until a new accept.
- Storage: output register (OR) plus one skid entry (SK). in_ready is registered and equals !SK_full.
- Accept: in_valid & in_ready at an edge.
  - If OR is empty, or OR is being consumed (out_valid & out_ready) with SK empty: the beat loads OR.
  - Otherwise the beat loads SK.
- Consume: out_valid & out_ready at an edge.
  - If SK is full, SK moves to OR and SK empties.
  - Else, if no beat is accepted this cycle, OR empties.
- Simultaneous accept + consume with SK full cannot occur, because in_ready=0 while SK is full.
- Latency: a beat accepted at edge N is visible on out_data/out_valid after edge N (1 cycle) when unstalled.
- Throughput: one beat per cycle with out_ready held high.
- Ordering: strictly FIFO.
- out_data is stable while out_valid & !out_ready.

Decomposition:
- Package fp_sign_pkg holds:
  - op enum: SIGN_COPY, SIGN_NEG, SIGN_XOR, SIGN_SETNEG.
  - Localparams HALF_BITS=16, SINGLE_BITS=32.
  - A function returning the sign bit index from PRECISION.
- Sub-module fp_skid_buf: parameterised-width 2-entry valid/ready register slice.
  - The top computes the result combinationally and feeds it to fp_skid_buf.
- Parameter legality is checked by an initial/generate assertion in the top.

Test Plan:
- HALF, back-to-back, out_ready=1:
  - COPY a=0x3C00, b=0x8000 -> 0xBC00.
  - NEG a=0xBC00 -> 0x3C00.
  - XOR a=0xC000, b=0x8000 -> 0x4000.
  - SETNEG a=0x0000 -> 0x8000.
  - Each appears 1 cycle after accept; in_ready stays 1.
- SINGLE (BITS=32):
  - COPY a=0x7FC00000 (NaN), b=0x80000000 -> 0xFFC00000.
  - NEG a=0x7F800000 -> 0xFF800000.
- Back-pressure:
  - Push 4 HALF beats 0x0001..0x0004 with op=SETNEG; hold out_ready=0 from cycle 1.
  - in_ready drops after the 2nd beat is accepted.
  - Release out_ready: outputs 0x8001, 0x8002, 0x8003, 0x8004 in order, none lost or duplicated.
- Stall stability: while out_valid=1 and out_ready=0 for 5 cycles, out_data is constant.
- Reset mid-operation:
  - Fill OR and SK, then assert rst_n=0 for 1 cycle.
  - Next cycle out_valid=0, out_data=0, in_ready=0.
  - The following cycle in_ready=1; no stale beat is ever emitted.
- Random stream: 10k beats, random in_valid/out_ready/op, checked against a scoreboard model for data and order.
